// File: rtl/venus_pkg.sv
// Venus-wide address constants and types, shared by fetch, instruction memory
// and the branch unit.
package venus_pkg;

  localparam int ADDR_W = 17;
  localparam logic [ADDR_W-1:0] RESET_ADDR = '0;

  typedef logic [ADDR_W-1:0] pc_addr_t;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational sequential-address adder: addr + INC modulo 2^ADDR_W, with the
// carry out of the top bit exposed for future use.
module pc_incrementer #(
  parameter int          ADDR_W = venus_pkg::ADDR_W,
  parameter int unsigned INC    = 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              carry_o
);

  logic [ADDR_W:0] sum;

  assign sum     = {1'b0, addr_i} + (ADDR_W+1)'(INC);
  assign addr_o  = sum[ADDR_W-1:0];
  assign carry_o = sum[ADDR_W];

endmodule

// File: rtl/program_counter.sv
// Instruction-fetch program counter: registered fetch address plus the
// combinational next address (redirect > stall > increment).
module program_counter #(
  parameter int          ADDR_W     = venus_pkg::ADDR_W,
  parameter int unsigned RESET_ADDR = 32'(venus_pkg::RESET_ADDR),
  parameter int unsigned INC        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set,
  input  logic              stall,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] next_pc
);

  if (INC < 1) begin : g_bad_inc
    $error("program_counter: INC must be at least 1");
  end
  if ((64'(RESET_ADDR) >> ADDR_W) != 64'd0) begin : g_bad_reset_addr
    $error("program_counter: RESET_ADDR does not fit in ADDR_W bits");
  end

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] inc_addr;
  logic              inc_carry_unused;

  pc_incrementer #(
    .ADDR_W (ADDR_W),
    .INC    (INC)
  ) u_inc (
    .addr_i  (addr_q),
    .addr_o  (inc_addr),
    .carry_o (inc_carry_unused)
  );

  // A redirect always wins so that a branch taken during a stall is not lost.
  always_comb begin
    addr_d = inc_addr;
    if (set) begin
      addr_d = addr_i;
    end else if (stall) begin
      addr_d = addr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= ADDR_W'(RESET_ADDR);
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o  = addr_q;
  assign next_pc = addr_d;

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized checks of program_counter against an arithmetic
// model of the fetch address.
module tb_program_counter;
  import venus_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     set;
  logic     stall;
  pc_addr_t addr_i;
  pc_addr_t addr_o;
  pc_addr_t next_pc;

  int n_tests = 0;
  int n_fail  = 0;

  pc_addr_t exp_pc;
  pc_addr_t exp_next;

  program_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (set),
    .stall   (stall),
    .addr_i  (addr_i),
    .addr_o  (addr_o),
    .next_pc (next_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input pc_addr_t obs, input pc_addr_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, check next_pc, then check addr_o
  // just after the rising edge. Always runs with reset released.
  task automatic step(input logic s, input logic st, input pc_addr_t a, input string tag);
    @(negedge clk);
    rst_n  = 1'b1;
    set    = s;
    stall  = st;
    addr_i = a;
    #1;
    if (s)       exp_next = a;
    else if (st) exp_next = exp_pc;
    else         exp_next = exp_pc + 17'd1;
    check({tag, "_next"}, next_pc, exp_next);
    @(posedge clk);
    #1;
    exp_pc = exp_next;
    check(tag, addr_o, exp_pc);
  endtask

  initial begin
    rst_n  = 1'b0;
    set    = 1'b0;
    stall  = 1'b0;
    addr_i = '0;
    exp_pc = '0;
    #1;
    check("reset_addr", addr_o, 17'h00000);
    check("reset_next", next_pc, 17'h00001);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", addr_o, 17'h00000);

    // Boot: load vector 0 for 4 cycles, then count.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 17'h00000, "boot_set");
    check("boot_set_const", addr_o, 17'h00000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 17'h1F0F0, "boot_run");
    check("boot_run_const", addr_o, 17'h00005);

    // Redirect while counting at 0x10.
    step(1'b1, 1'b0, 17'h0000E, "redir_pre");
    step(1'b0, 1'b0, 17'h00000, "redir_cnt");
    step(1'b0, 1'b0, 17'h00000, "redir_cnt");
    check("redir_at10", addr_o, 17'h00010);
    step(1'b1, 1'b0, 17'h0ABCD, "redir_load");
    check("redir_const", addr_o, 17'h0ABCD);
    step(1'b0, 1'b0, 17'h00000, "redir_inc");
    check("redir_inc_const", addr_o, 17'h0ABCE);

    // Wrap past the top of the address space.
    step(1'b1, 1'b0, 17'h1FFFE, "wrap_load");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 17'h00000, "wrap_run");
    check("wrap_const", addr_o, 17'h00001);

    // Stall holds; set beats stall.
    step(1'b1, 1'b0, 17'h00020, "stall_load");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 17'h1ABCD, "stall_hold");
    check("stall_const", addr_o, 17'h00020);
    step(1'b1, 1'b1, 17'h00400, "stall_set");
    check("stall_set_const", addr_o, 17'h00400);

    // Back-to-back redirects.
    step(1'b1, 1'b0, 17'h01111, "b2b");
    step(1'b1, 1'b0, 17'h02222, "b2b");
    step(1'b1, 1'b1, 17'h03333, "b2b");

    // Asynchronous reset mid-cycle at 0x123, overriding a pending set.
    step(1'b1, 1'b0, 17'h00123, "rst_pre");
    @(negedge clk);
    #2;
    set    = 1'b1;
    addr_i = 17'h00777;
    rst_n  = 1'b0;
    #1;
    exp_pc = 17'h00000;
    check("rst_async", addr_o, 17'h00000);
    check("rst_async_next", next_pc, 17'h00777);
    @(posedge clk);
    #1;
    check("rst_held", addr_o, 17'h00000);
    step(1'b0, 1'b0, 17'h00000, "rst_release");
    check("rst_release_const", addr_o, 17'h00001);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic     s, st;
      pc_addr_t a;
      s  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0);
      a  = 17'($urandom);
      if ($urandom_range(0, 15) == 0) a = 17'h1FFFF;
      step(s, st, a, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
